// File: rtl/nvme_slot_pkg.sv
// Shared definitions for the NVMe slot-number SGPIO transmitter.
// Holds the frame FSM state type and the default link parameters.
package nvme_slot_pkg;

  localparam int unsigned NVME_SLOT_W     = 100;
  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_REFRESH_CYC = 2500000;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StGap
  } tx_state_e;

endpackage

// File: rtl/sgpio_tick_gen.sv
// Divider producing a one-clk tick every CLK_DIV cycles while run is high.
// The count restarts from zero whenever run drops.
module sgpio_tick_gen
  import nvme_slot_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CntMax);

endmodule

// File: rtl/nvme_slot_sgpio_tx.sv
// Serialises the active-low slot-number vector onto sclk/sload/sdata,
// sending on vector change, on first enable after reset and on a refresh timer.
module nvme_slot_sgpio_tx
  import nvme_slot_pkg::*;
#(
  parameter int unsigned WIDTH       = NVME_SLOT_W,
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned REFRESH_CYC = DEF_REFRESH_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] slot_vec,
  output logic             sclk,
  output logic             sload,
  output logic             sdata,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
);

  localparam logic [6:0]  LastIdx    = 7'(WIDTH - 1);
  localparam logic [6:0]  GapLastTk  = 7'd3;
  localparam logic [31:0] RefreshMax = 32'(REFRESH_CYC - 1);

  tx_state_e        state_q, state_d;
  logic             phase_q, phase_d;  // 0: sclk-low tick, 1: sclk-high tick
  logic [6:0]       idx_q, idx_d;      // bit index in SHIFT, tick count in GAP
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             first_pend_q, first_pend_d;
  logic [31:0]      refresh_q, refresh_d;
  logic             sclk_q, sclk_d;
  logic             sload_q, sload_d;
  logic             sdata_q, sdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             tick;
  logic             trigger;

  sgpio_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (busy_q),
    .tick (tick)
  );

  assign trigger = en && (first_pend_q || (slot_vec != last_q) || (refresh_q == RefreshMax));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (trigger) state_d = StLoad;
      StLoad:  if (tick && phase_q) state_d = StShift;
      StShift: if (tick && phase_q && (idx_q == LastIdx)) state_d = StGap;
      StGap:   if (tick && (idx_q == GapLastTk)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_d      = phase_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    last_d       = last_q;
    first_pend_d = first_pend_q;
    refresh_d    = refresh_q;
    sclk_d       = sclk_q;
    sload_d      = sload_q;
    sdata_d      = sdata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en) refresh_d = refresh_q + 32'd1;
        if (trigger) begin
          snap_d       = slot_vec;
          last_d       = slot_vec;
          first_pend_d = 1'b0;
          refresh_d    = '0;
          busy_d       = 1'b1;
          sload_d      = 1'b1;
          sdata_d      = 1'b0;
          sclk_d       = 1'b0;
          phase_d      = 1'b0;
          idx_d        = '0;
        end
      end
      StLoad: begin
        if (tick) begin
          phase_d = ~phase_q;
          sclk_d  = ~phase_q;
          if (phase_q) begin
            sload_d = 1'b0;
            sdata_d = snap_q[0];
            snap_d  = snap_q >> 1;
            idx_d   = '0;
          end
        end
      end
      StShift: begin
        if (tick) begin
          phase_d = ~phase_q;
          sclk_d  = ~phase_q;
          // New data is launched together with the falling sclk edge.
          if (phase_q) begin
            if (idx_q == LastIdx) begin
              sdata_d = 1'b0;
              idx_d   = '0;
            end else begin
              sdata_d = snap_q[0];
              snap_d  = snap_q >> 1;
              idx_d   = idx_q + 7'd1;
            end
          end
        end
      end
      StGap: begin
        if (tick) begin
          idx_d = idx_q + 7'd1;
          if (idx_q == GapLastTk) begin
            idx_d       = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= 1'b0;
      idx_q        <= '0;
      snap_q       <= '0;
      last_q       <= '1;
      first_pend_q <= 1'b1;
      refresh_q    <= '0;
      sclk_q       <= 1'b0;
      sload_q      <= 1'b0;
      sdata_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      last_q       <= last_d;
      first_pend_q <= first_pend_d;
      refresh_q    <= refresh_d;
      sclk_q       <= sclk_d;
      sload_q      <= sload_d;
      sdata_q      <= sdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign sclk       = sclk_q;
  assign sload      = sload_q;
  assign sdata      = sdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_nvme_slot_sgpio_tx.sv
// Bench for nvme_slot_sgpio_tx: a BMC-side receiver rebuilds each frame from
// the link and the tasks compare it with vectors and timing derived from the frame rules.
module tb_nvme_slot_sgpio_tx;

  localparam int W    = 100;
  localparam int CDIV = 4;
  localparam int RCYC = 1000;
  localparam int FLEN = (1 + W + 2) * 2 * CDIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  slot_vec;
  logic          sclk, sload, sdata, busy, frame_done;
  logic [15:0]   frame_cnt;
  logic          sclk_d2, sload_d2, sdata_d2, busy_d2, done_d2;
  logic [15:0]   cnt_d2;
  logic          sclk_d7, sload_d7, sdata_d7, busy_d7, done_d7;
  logic [15:0]   cnt_d7;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nvme_slot_sgpio_tx #(.WIDTH(W), .CLK_DIV(CDIV), .REFRESH_CYC(RCYC)) dut (
    .clk(clk), .rst(rst), .en(en), .slot_vec(slot_vec), .sclk(sclk), .sload(sload),
    .sdata(sdata), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  nvme_slot_sgpio_tx #(.WIDTH(W), .CLK_DIV(2), .REFRESH_CYC(RCYC)) dut_d2 (
    .clk(clk), .rst(rst), .en(en), .slot_vec(slot_vec), .sclk(sclk_d2), .sload(sload_d2),
    .sdata(sdata_d2), .busy(busy_d2), .frame_done(done_d2), .frame_cnt(cnt_d2)
  );

  nvme_slot_sgpio_tx #(.WIDTH(W), .CLK_DIV(7), .REFRESH_CYC(RCYC)) dut_d7 (
    .clk(clk), .rst(rst), .en(en), .slot_vec(slot_vec), .sclk(sclk_d7), .sload(sload_d7),
    .sdata(sdata_d7), .busy(busy_d7), .frame_done(done_d7), .frame_cnt(cnt_d7)
  );

  typedef struct {
    logic [W-1:0] bits;
    int           rises;
    int           start;
    int           done;
    int           terr;
  } frame_t;

  frame_t      fq[$];
  frame_t      cur;
  bit          mon_in = 0;
  logic        mon_pb = 1'b0, mon_ps = 1'b0, mon_pd = 1'b0;
  logic [15:0] exp_cnt = '0;
  int          last_done = 0;

  // Receiver model: samples sdata at each sclk rise and checks rise times.
  initial forever begin
    @(negedge clk);
    if (rst !== 1'b1) begin
      mon_in = 0; mon_pb = 1'b0; mon_ps = 1'b0; mon_pd = 1'b0;
    end else begin
      if (busy && !mon_pb) begin
        mon_in = 1; cur.bits = '0; cur.rises = 0; cur.start = cyc; cur.terr = 0;
      end
      if (mon_in) begin
        if (sclk && mon_ps && (sdata !== mon_pd)) cur.terr++;
        if (sclk && !mon_ps) begin
          if (cyc - cur.start != (2 * cur.rises + 1) * CDIV) cur.terr++;
          if (cur.rises == 0) begin
            if (sload !== 1'b1 || sdata !== 1'b0) cur.terr++;
          end else begin
            if (sload !== 1'b0) cur.terr++;
            if (cur.rises <= W) cur.bits[cur.rises-1] = sdata;
          end
          cur.rises++;
        end
        if (frame_done) begin
          cur.done = cyc; fq.push_back(cur); mon_in = 0;
        end
      end
      mon_pb = busy; mon_ps = sclk; mon_pd = sdata;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic wait_frame(input int budget, output frame_t f, output bit got);
    got = 0;
    for (int i = 0; i < budget && fq.size() == 0; i++) step();
    if (fq.size() != 0) begin
      f = fq.pop_front(); got = 1;
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < FLEN + 100; i++) begin
      step();
      if (mon_in && cur.rises >= n) begin ok = 1; break; end
    end
  endtask

  task automatic check_frame(input string nm, input frame_t f, input logic [W-1:0] v,
                             input int exp_start);
    nvec++;
    if (f.bits !== v) begin
      nfail++; $display("FAIL %s_bits: got %h want %h", nm, f.bits, v);
    end
    nvec++;
    if (f.done - f.start != FLEN || f.rises != W + 1 || f.terr != 0) begin
      nfail++;
      $display("FAIL %s_shape: got len %0d rises %0d terr %0d want len %0d rises %0d terr 0",
               nm, f.done - f.start, f.rises, f.terr, FLEN, W + 1);
    end
    if (exp_start >= 0) begin
      nvec++;
      if (f.start != exp_start) begin
        nfail++; $display("FAIL %s_start: got cyc %0d want cyc %0d", nm, f.start, exp_start);
      end
    end
  endtask

  task automatic check_cnt(input string nm);
    nvec++;
    if (frame_cnt !== exp_cnt) begin
      nfail++; $display("FAIL %s_cnt: got %0d want %0d", nm, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    int nbusy;
    nbusy = 0;
    rst = 1'b0; en = 1'b0; slot_vec = ~W'(5);
    repeat (3) step();
    nvec++;
    if ({sclk, sload, sdata, busy, frame_done, frame_cnt} !== 21'd0) begin
      nfail++;
      $display("FAIL reset_outputs: got %b want 0", {sclk, sload, sdata, busy, frame_done, frame_cnt});
    end
    rst = 1'b1;
    repeat (40) begin step(); if (busy) nbusy++; end
    nvec++;
    if (nbusy != 0 || fq.size() != 0) begin
      nfail++; $display("FAIL reset_en_low_idle: got busy cycles %0d want 0", nbusy);
    end
  endtask

  task automatic test_first_frame();
    frame_t f; bit got; int t;
    en = 1'b1; t = cyc;
    wait_frame(FLEN + 50, f, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL first_frame_timeout: got none want frame"); end
    check_frame("first", f, ~W'(5), t + 1);
    exp_cnt++;
    check_cnt("first");
    last_done = f.done;
    step();
    nvec++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      nfail++; $display("FAIL first_done_pulse: got done %b busy %b want 0 0", frame_done, busy);
    end
  endtask

  task automatic test_refresh();
    frame_t f; bit got; int nbusy; int t;
    nbusy = 0;
    wait_frame(RCYC + FLEN + 50, f, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL refresh_timeout: got none want frame"); end
    check_frame("refresh", f, ~W'(5), last_done + RCYC);
    exp_cnt++;
    check_cnt("refresh");
    en = 1'b0;
    repeat (RCYC + 500) begin step(); if (busy) nbusy++; end
    nvec++;
    if (nbusy != 0 || fq.size() != 0) begin
      nfail++; $display("FAIL refresh_en_low: got busy cycles %0d want 0", nbusy);
    end
    // Refresh count restarted at the last frame and held while disabled.
    en = 1'b1; t = cyc;
    wait_frame(RCYC + FLEN + 50, f, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL refresh_hold_timeout: got none want frame"); end
    check_frame("refresh_hold", f, ~W'(5), t + RCYC);
    exp_cnt++;
    check_cnt("refresh_hold");
  endtask

  task automatic test_back_to_back();
    frame_t fa, fb; bit got, ok; logic [W-1:0] v, v2; int t;
    v = rand_vec(); v[17] = 1'b0;
    slot_vec = v; t = cyc;
    wait_rises(42, ok);
    nvec++;
    if (!ok) begin nfail++; $display("FAIL b2b_reach_idx40: got no rise want rise 42"); end
    v2 = v; v2[17] = 1'b1;
    slot_vec = v2;
    wait_frame(FLEN + 50, fa, got);
    check_frame("b2b_old", fa, v, t + 1);
    wait_frame(FLEN + 50, fb, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL b2b_timeout: got none want second frame"); end
    check_frame("b2b_new", fb, v2, fa.done + 1);
    exp_cnt += 16'd2;
    check_cnt("b2b");
  endtask

  task automatic test_en_drop();
    frame_t f; bit got, ok; logic [W-1:0] v; int t; int nbusy;
    nbusy = 0;
    v = rand_vec();
    slot_vec = v; t = cyc;
    wait_rises(20, ok);
    en = 1'b0;
    wait_frame(FLEN + 50, f, got);
    nvec++;
    if (!got || !ok) begin nfail++; $display("FAIL en_drop_timeout: got %0d want 1", got); end
    check_frame("en_drop", f, v, t + 1);
    exp_cnt++;
    check_cnt("en_drop");
    slot_vec = rand_vec();
    repeat (300) begin step(); if (busy) nbusy++; end
    nvec++;
    if (nbusy != 0 || fq.size() != 0) begin
      nfail++; $display("FAIL en_drop_no_frame: got busy cycles %0d want 0", nbusy);
    end
  endtask

  task automatic test_rst_mid_shift();
    frame_t f; bit got, ok; logic [W-1:0] v; int t;
    v = slot_vec;
    en = 1'b1;
    wait_rises(30, ok);
    rst = 1'b0;
    #1;
    nvec++;
    if (!ok || {sclk, sload, sdata, busy, frame_done, frame_cnt} !== 21'd0) begin
      nfail++;
      $display("FAIL rst_mid_outputs: got %b want 0", {sclk, sload, sdata, busy, frame_done, frame_cnt});
    end
    exp_cnt = '0;
    repeat (3) step();
    nvec++;
    if (fq.size() != 0) begin nfail++; $display("FAIL rst_mid_lost: got %0d frames want 0", fq.size()); end
    rst = 1'b1; t = cyc;
    wait_frame(FLEN + 50, f, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL rst_resend_timeout: got none want frame"); end
    check_frame("rst_resend", f, v, t + 1);
    exp_cnt++;
    check_cnt("rst_resend");
  endtask

  task automatic test_wrap();
    frame_t f; bit got; logic [W-1:0] v;
    en = 1'b0;
    step();
    force dut.frame_cnt_q = 16'hFFFF;
    repeat (2) step();
    release dut.frame_cnt_q;
    step();
    exp_cnt = 16'hFFFF;
    check_cnt("wrap_preset");
    v = rand_vec();
    slot_vec = v; en = 1'b1;
    wait_frame(FLEN + 50, f, got);
    nvec++;
    if (!got) begin nfail++; $display("FAIL wrap_timeout: got none want frame"); end
    check_frame("wrap", f, v, -1);
    exp_cnt++;
    check_cnt("wrap");
  endtask

  task automatic test_clk_div();
    int cd[2]; int t0[2]; int last[2]; int rises[2]; int perr[2]; int len[2];
    logic [W-1:0] bits[2]; logic s[2]; logic d[2]; logic ld[2]; logic b[2]; logic fd[2];
    logic ps[2]; logic pb[2]; logic [15:0] fc[2]; logic [W-1:0] v;
    cd[0] = 2; cd[1] = 7;
    v = rand_vec();
    rst = 1'b0; en = 1'b0;
    step();
    slot_vec = v; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      t0[k] = -1; last[k] = 0; rises[k] = 0; perr[k] = 0; len[k] = -1;
      bits[k] = '0; ps[k] = 1'b0; pb[k] = 1'b0;
    end
    rst = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      step();
      s[0] = sclk_d2; d[0] = sdata_d2; ld[0] = sload_d2; b[0] = busy_d2; fd[0] = done_d2;
      s[1] = sclk_d7; d[1] = sdata_d7; ld[1] = sload_d7; b[1] = busy_d7; fd[1] = done_d7;
      for (int k = 0; k < 2; k++) begin
        if (b[k] && !pb[k] && t0[k] < 0) t0[k] = cyc;
        if (t0[k] >= 0 && len[k] < 0) begin
          if (s[k] && !ps[k]) begin
            if (rises[k] == 0) begin
              if (cyc - t0[k] != cd[k] || ld[k] !== 1'b1) perr[k]++;
            end else begin
              if (cyc - last[k] != 2 * cd[k]) perr[k]++;
              if (rises[k] <= W) bits[k][rises[k]-1] = d[k];
            end
            last[k] = cyc; rises[k]++;
          end
          if (fd[k]) len[k] = cyc - t0[k];
        end
        ps[k] = s[k]; pb[k] = b[k];
      end
      if (len[0] >= 0 && len[1] >= 0) break;
    end
    fq.delete();
    fc[0] = cnt_d2; fc[1] = cnt_d7;
    for (int k = 0; k < 2; k++) begin
      nvec++;
      if (perr[k] != 0 || rises[k] != W + 1) begin
        nfail++;
        $display("FAIL clk_div%0d_period: got errors %0d rises %0d want 0 and %0d",
                 cd[k], perr[k], rises[k], W + 1);
      end
      nvec++;
      if (len[k] != (1 + W + 2) * 2 * cd[k] || fc[k] !== 16'd1) begin
        nfail++;
        $display("FAIL clk_div%0d_len: got %0d cnt %0d want %0d cnt 1",
                 cd[k], len[k], fc[k], (1 + W + 2) * 2 * cd[k]);
      end
      nvec++;
      if (bits[k] !== v) begin
        nfail++; $display("FAIL clk_div%0d_bits: got %h want %h", cd[k], bits[k], v);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; slot_vec = '0;
    test_reset();
    test_first_frame();
    test_refresh();
    test_back_to_back();
    test_en_drop();
    test_rst_mid_shift();
    test_wrap();
    test_clk_div();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
